// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: serial scan-chain master, shifts data_in out MSB-first while capturing data_out.
// Define SCAN_LOAD_EN to add the SC_load shadow-register strobe ahead of SC_done.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 100,
  parameter int CLK_DIV   = 50
) (
  input  logic                 clki,
  input  logic                 reset,
  input  logic                 SC_clk_enb,
  input  logic                 SC_data_enb,
  input  logic [CHAIN_LEN-1:0] data_in,
  input  logic                 data_out,
  output logic                 SC_data,
  output logic                 SC_clk_chip,
  output logic [CHAIN_LEN-1:0] SC_out,
  output logic                 SC_done
`ifdef SCAN_LOAD_EN
  ,
  output logic                 SC_load
`endif
);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, LOAD, DONE} state_t;
  state_t               state;
  logic [1:0]           sync;
  logic                 en_d;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits;
  logic [CHAIN_LEN:0]   sr;
  logic [CHAIN_LEN-1:0] stream;
  logic                 busy, start, last;
  assign stream = SC_data_enb ? data_in : '0;
  assign busy   = state == SETUP || state == HIGH || state == LOW;
  assign start  = sync[1] && !en_d;
  assign last   = cnt == CW'(CLK_DIV - 1);
  // sr[CHAIN_LEN] mirrors the bit currently on SC_data; sr[CHAIN_LEN-1] is the next one
  always_ff @(posedge clki) begin
    if (reset) begin
      state       <= IDLE;
      sync        <= '0;
      en_d        <= 1'b0;
      cnt         <= '0;
      bits        <= '0;
      sr          <= '0;
      SC_data     <= 1'b0;
      SC_clk_chip <= 1'b0;
      SC_out      <= '0;
      SC_done     <= 1'b0;
`ifdef SCAN_LOAD_EN
      SC_load     <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], SC_clk_enb};
      en_d <= sync[1];
      cnt  <= cnt + CW'(1);
      if (busy && !sync[1]) begin
        state       <= IDLE;
        SC_clk_chip <= 1'b0;
        SC_data     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state   <= SETUP;
            cnt     <= '0;
            bits    <= '0;
            sr      <= {stream, 1'b0};
            SC_data <= stream[CHAIN_LEN-1];
            SC_done <= 1'b0;
          end
          SETUP: if (last) begin
            state       <= HIGH;
            cnt         <= '0;
            SC_clk_chip <= 1'b1;
          end
          HIGH: if (last) begin
            state       <= LOW;
            cnt         <= '0;
            SC_clk_chip <= 1'b0;
            SC_out      <= CHAIN_LEN'({SC_out, data_out});
            sr          <= sr << 1;
            SC_data     <= sr[CHAIN_LEN-1];
          end
          LOW: if (last) begin
            cnt <= '0;
            if (bits == BW'(CHAIN_LEN - 1)) begin
              SC_data <= 1'b0;
`ifdef SCAN_LOAD_EN
              state   <= LOAD;
              SC_load <= 1'b1;
`else
              state   <= DONE;
              SC_done <= 1'b1;
`endif
            end else begin
              state       <= HIGH;
              bits        <= bits + BW'(1);
              SC_clk_chip <= 1'b1;
            end
          end
`ifdef SCAN_LOAD_EN
          LOAD: if (cnt == CW'(2 * CLK_DIV - 1)) begin
            state   <= DONE;
            SC_load <= 1'b0;
            SC_done <= 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: randomized scan operations checked against a chip/loopback reference model.
module tb_scan_chain_ctrl;
  localparam int N = 100;
  localparam int D = 2;
`ifdef SCAN_LOAD_EN
  localparam int LAT = D * (2 * N + 3);
`else
  localparam int LAT = D * (2 * N + 1);
`endif
  logic clki = 1'b0;
  logic reset, SC_clk_enb, SC_data_enb, data_out, SC_data, SC_clk_chip, SC_done;
  logic [N-1:0] data_in, SC_out;
`ifdef SCAN_LOAD_EN
  logic SC_load;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int pulses = 0, hi_cyc = 0, bad_run = 0, run = 0, data_hi = 0, done_cyc = 0, load_cyc = 0, load_rise = 0;
  logic prev_clk = 1'b0, prev_done = 1'b0, prev_load = 1'b0;
  logic done_exp = 1'b0, loop = 1'b1, chip_ld = 1'b0, chip_in = 1'b0;
  logic [N-1:0] chip = '0, chip_pre = '0, din;
  int s, p0, h0, b0, d0, l0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CLK_DIV(D)) dut (
    .clki(clki), .reset(reset), .SC_clk_enb(SC_clk_enb), .SC_data_enb(SC_data_enb),
    .data_in(data_in), .data_out(data_out), .SC_data(SC_data), .SC_clk_chip(SC_clk_chip),
    .SC_out(SC_out), .SC_done(SC_done)
`ifdef SCAN_LOAD_EN
    , .SC_load(SC_load)
`endif
  );

  always #5 clki = ~clki;
  always @(posedge clki) cyc++;

  // chip: samples SC_data on the rising scan clock, shifts on the falling one, returns its MSB
  assign data_out = loop ? SC_data : chip[N-1];
  always @(posedge SC_clk_chip) chip_in = SC_data;
  always @(negedge SC_clk_chip or posedge chip_ld)
    if (chip_ld) chip = chip_pre;
    else chip = {chip[N-2:0], chip_in};

  always @(negedge clki) begin
    if (SC_clk_chip) begin
      hi_cyc++;
      run++;
      if (!prev_clk) pulses++;
    end else if (prev_clk) begin
      if (run != D) bad_run++;
      run = 0;
    end
    if (SC_done && !prev_done) done_cyc = cyc;
    if (SC_data) data_hi++;
`ifdef SCAN_LOAD_EN
    if (SC_load) begin
      load_cyc++;
      if (!prev_load) load_rise = cyc;
    end
    prev_load = SC_load;
`endif
    prev_clk = SC_clk_chip;
    prev_done = SC_done;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    logic [127:0] t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[N-1:0];
  endfunction

  task automatic start_op(input logic [N-1:0] d, input logic enb, input logic lp, input logic [N-1:0] pre);
    SC_clk_enb = 1'b0;
    repeat (4) @(negedge clki);
    data_in = d;
    SC_data_enb = enb;
    loop = lp;
    chip_pre = pre;
    chip_ld = 1'b1;
    #1 chip_ld = 1'b0;
    p0 = pulses; h0 = hi_cyc; b0 = bad_run; d0 = data_hi; l0 = load_cyc;
    SC_clk_enb = 1'b1;
    s = cyc + 3;
    repeat (2) @(negedge clki);
    check("done_before_s", SC_done, done_exp);
    @(negedge clki);
    check("done_at_s", SC_done, 0);
    repeat (D - 1) @(negedge clki);
    check("setup_clk_low", SC_clk_chip, 0);
    @(negedge clki);
    check("first_pulse", SC_clk_chip, 1);
  endtask

  task automatic run_op(input logic [N-1:0] d, input logic enb, input logic lp, input logic [N-1:0] pre);
    logic [N-1:0] stream = enb ? d : '0;
    start_op(d, enb, lp, pre);
    for (int i = 0; i < 3000 && SC_done !== 1'b1; i++) @(negedge clki);
    #1;
    check("done", SC_done, 1);
    check("pulses", pulses - p0, N);
    check("hi_total", hi_cyc - h0, N * D);
    check("hi_width", bad_run - b0, 0);
    check("done_lat", done_cyc - s, LAT);
    check("sc_out", SC_out, lp ? stream : pre);
    if (!lp) check("chip", chip, stream);
    if (!enb) check("data_quiet", data_hi - d0, 0);
`ifdef SCAN_LOAD_EN
    check("load_len", load_cyc - l0, 2 * D);
    check("load_start", load_rise - s, D * (2 * N + 1));
`endif
    repeat (20) @(negedge clki);
    #1;
    check("no_restart", pulses - p0, N);
    check("done_hold", SC_done, 1);
    done_exp = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    SC_clk_enb = 1'b0;
    SC_data_enb = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clki);
    check("rst_clk", SC_clk_chip, 0);
    check("rst_data", SC_data, 0);
    check("rst_done", SC_done, 0);
    check("rst_out", SC_out, 0);
    reset = 1'b0;
    din = 100'h003F_FFFF_FFFF_0003A_5A5A_5A5A;
    run_op(din, 1'b1, 1'b1, '0);
    run_op(rnd(), 1'b0, 1'b0, 100'h1);
    run_op('1, 1'b1, 1'b1, '0);
    for (int k = 0; k < 6; k++) run_op(rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd());
    // abort after ten pulses
    start_op(rnd(), 1'b1, 1'b1, '0);
    for (int i = 0; i < 500 && pulses - p0 < 10; i++) begin
      @(negedge clki);
      #1;
    end
    check("abort_reach", pulses - p0, 10);
    SC_clk_enb = 1'b0;
    repeat (3) @(negedge clki);
    check("abort_clk", SC_clk_chip, 0);
    check("abort_data", SC_data, 0);
    repeat (50) @(negedge clki);
    #1;
    check("abort_pulses", pulses - p0, 10);
    check("abort_done", SC_done, 0);
    done_exp = 1'b0;
    run_op(rnd(), 1'b1, 1'b0, rnd());
    // reset in the middle of shifting
    start_op(rnd(), 1'b1, 1'b1, '0);
    repeat (60) @(negedge clki);
    reset = 1'b1;
    SC_clk_enb = 1'b0;
    @(negedge clki);
    check("mid_rst_clk", SC_clk_chip, 0);
    check("mid_rst_data", SC_data, 0);
    check("mid_rst_done", SC_done, 0);
    check("mid_rst_out", SC_out, 0);
    repeat (2) @(negedge clki);
    reset = 1'b0;
    done_exp = 1'b0;
    run_op(rnd(), 1'b1, 1'b1, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Serial scan-chain master between the host wire-in registers and the test chip. On a host start request it generates a divided, gated scan clock and shifts a CHAIN_LEN-bit configuration word out to the chip MSB-first. At the same time it captures the chip's serial return stream into a parallel word. It then raises a done flag whose rising edge the top level uses to latch the captured word into wire-outs.

Parameters:
CHAIN_LEN, 100, number of scan bits per operation (width of data_in/SC_out)
CLK_DIV, 50, clki cycles per scan-clock half period (50 gives 1 MHz at 100 MHz clki); legal range ≥1

Ports:
clki  input  1  system clock (100 MHz), all logic on posedge
reset  input  1  synchronous, active-high reset
SC_clk_enb  input  1  host start/enable level (asynchronous to clki)
SC_data_enb  input  1  1 = shift data_in to chip; 0 = shift zeros (read-only scan)
data_in  input  CHAIN_LEN  word to load; bit CHAIN_LEN-1 is shifted first
data_out  input  1  serial return from chip
SC_data  output  1  serial data to chip
SC_clk_chip  output  1  scan clock to chip
SC_out  output  CHAIN_LEN  captured return word
SC_done  output  1  operation complete flag

Behaviour:
- Reset: state IDLE, SC_data=0, SC_clk_chip=0, SC_out=0, SC_done=0, synchronizer flops=0, counters=0.
- SC_clk_enb passes through a 2-flop synchronizer. Start = synchronized rising edge (0→1), detected in IDLE or DONE. S = first cycle after detection.
- States: IDLE → SETUP → HIGH ↔ LOW → DONE. With N=CHAIN_LEN and D=CLK_DIV:
  - SETUP: cycles S..S+D-1, SC_clk_chip=0, SC_data = bit 0 of the stream.
  - Pulse k (k=0..N-1): HIGH at cycles S+D(2k+1)..S+D(2k+2)-1 with SC_clk_chip=1, then LOW for D cycles with SC_clk_chip=0.
  - The bit of the stream for pulse k+1 is driven on SC_data in the first LOW cycle after pulse k.
  - Stream bit k = data_in[N-1-k] when SC_data_enb=1, else 0. data_in and SC_data_enb are sampled into an internal shift register at S. Later changes are ignored until the next start.
- Capture: on the last clki cycle of each HIGH phase, data_out is shifted into SC_out from the LSB (SC_out <= {SC_out[N-2:0], data_out}). The first captured bit therefore ends in SC_out[N-1].
- After the LOW phase of pulse N-1 the state goes to DONE and SC_done=1 at cycle S+D(2N+1). SC_out is final no later than that cycle and holds while in DONE.
- DONE: SC_clk_chip=0, SC_data=0. SC_done stays 1 until a new start or reset. A new start clears SC_done at S and clears nothing else; SC_out keeps its old value until overwritten bit-by-bit.
- Abort: if synchronized SC_clk_enb falls during SETUP/HIGH/LOW, go to IDLE next cycle. SC_clk_chip=0, SC_data=0, SC_done stays 0, SC_out keeps partial content.
- A synchronized level held high after completion causes no restart; an edge is required.
- Reset mid-operation returns everything to reset values the next cycle.
- Exactly N scan-clock pulses per completed operation. There are no glitches on SC_clk_chip: it is a registered output.

Optional Feature:
SCAN_LOAD_EN: when defined, adds output port SC_load (1 bit, reset 0). It is driven high for exactly 2*CLK_DIV clki cycles, starting at the cycle after the last LOW phase, to latch the chip's shadow register. SC_done then rises after SC_load falls, at S+D(2N+3). When not defined, the port is absent and SC_done timing is as stated in Behaviour.

Test Plan:
- Reset: assert reset 3 cycles mid-shift (CLK_DIV=2) → next cycle SC_clk_chip=0, SC_data=0, SC_done=0, SC_out=0.
- Loopback (data_out tied to SC_data), CLK_DIV=2, data_in=100'h0_0003F_FFFF_FFFF_0003A_5A5A_5A5A, SC_data_enb=1, raise SC_clk_enb → exactly 100 SC_clk_chip pulses, each high 2 cycles; SC_done rises 402 cycles after S; SC_out == data_in.
- Read-only: SC_data_enb=0, data_out driven from a chip model preloaded with 100'h1 → SC_data stays 0 throughout; SC_out == 100'h1 (bit 0 captured last); chip model ends all zeros.
- Retrigger: after done, drop and re-raise SC_clk_enb with data_in=all-ones (loopback) → SC_done goes 0 at new S and back to 1 after 402 cycles; SC_out = all-ones.
- Abort: drop SC_clk_enb after 10 pulses → SC_clk_chip stops low within 3 cycles (sync + 1); SC_done stays 0; no further pulses.
- With SCAN_LOAD_EN, CLK_DIV=2: SC_load high for 4 cycles starting at S+402; SC_done rises at S+406.
